prbs_checker: RTL and testbench

//  Self-synchronising PRBS7 (x^7+x^6+1) checker for 32-bit parallel frames.

---
 rtl/prbs_checker.sv | 157 +++++++++++++++
 tb/tb_prbs_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS7 (x^7+x^6+1) checker for parallel frames.
// Tracks lock on the incoming stream and accumulates a saturating bit-error count.
module prbs_checker #(
    parameter int WORD_W     = 32,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              locked,
    output logic              word_err,
    output logic [5:0]        err_bits,
    output logic [CNT_W-1:0]  err_count
);

    localparam int LC_W = $clog2(LOCK_CNT + 1);
    localparam int UC_W = $clog2(UNLOCK_CNT + 1);

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Bit i of the result flags a recurrence violation at in_data[i]; bits
    // above the word come from the history, oldest in the MSB.
    function automatic logic [WORD_W-1:0] mismatch_vec(input logic [6:0] hist,
                                                        input logic [WORD_W-1:0] data);
        logic [WORD_W+6:0] cat_v;
        logic [WORD_W-1:0] res_v;
        cat_v = {hist, data};
        for (int i = 0; i < WORD_W; i++) begin
            res_v[i] = cat_v[i] ^ cat_v[i+6] ^ cat_v[i+7];
        end
        return res_v;
    endfunction

    function automatic logic [5:0] popcount(input logic [WORD_W-1:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    state_t            state_r, state_nxt;
    logic [LC_W-1:0]   lock_cnt_r, lock_cnt_nxt, lock_inc_s;
    logic [UC_W-1:0]   unlock_cnt_r, unlock_cnt_nxt, unlock_inc_s;
    logic [6:0]        hist_r, hist_nxt;
    logic              locked_r, word_err_r, word_err_nxt, word_err_upd_s;
    logic [5:0]        err_bits_r, err_bits_nxt, err_bits_s;
    logic [CNT_W-1:0]  err_count_r, err_count_nxt, err_count_upd_s, sat_sum_s;
    logic [CNT_W:0]    sum_s;
    logic              zero_guard_s, word_bad_s;

    // An all-zero word on an all-zero history would pass the recurrence, so it is forced errored.
    assign zero_guard_s = (in_data == {WORD_W{1'b0}}) && (hist_r == 7'd0);
    assign err_bits_s   = zero_guard_s ? 6'(WORD_W) : popcount(mismatch_vec(hist_r, in_data));
    assign word_bad_s   = (err_bits_s != 6'd0);
    assign lock_inc_s   = lock_cnt_r + LC_W'(1);
    assign unlock_inc_s = unlock_cnt_r + UC_W'(1);
    assign sum_s        = {1'b0, err_count_r} + {{(CNT_W-5){1'b0}}, err_bits_s};
    assign sat_sum_s    = sum_s[CNT_W] ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];

    // Next-state, counter and output computation for one accepted word.
    always_comb begin
        state_nxt       = state_r;
        lock_cnt_nxt    = lock_cnt_r;
        unlock_cnt_nxt  = unlock_cnt_r;
        hist_nxt        = hist_r;
        err_bits_nxt    = err_bits_r;
        word_err_upd_s  = 1'b0;
        err_count_upd_s = err_count_r;
        word_err_nxt    = 1'b0;
        err_count_nxt   = err_count_r;
        if (in_valid) begin
            hist_nxt     = in_data[6:0];
            err_bits_nxt = err_bits_s;
            case (state_r)
                SEARCH: begin
                    if (word_bad_s) begin
                        lock_cnt_nxt = {LC_W{1'b0}};
                    end else if (lock_inc_s == LC_W'(LOCK_CNT)) begin
                        state_nxt      = LOCKED;
                        lock_cnt_nxt   = {LC_W{1'b0}};
                        unlock_cnt_nxt = {UC_W{1'b0}};
                    end else begin
                        lock_cnt_nxt = lock_inc_s;
                    end
                end
                LOCKED: begin
                    if (word_bad_s) begin
                        word_err_upd_s  = 1'b1;
                        err_count_upd_s = sat_sum_s;
                        if (unlock_inc_s == UC_W'(UNLOCK_CNT)) begin
                            state_nxt      = SEARCH;
                            lock_cnt_nxt   = {LC_W{1'b0}};
                            unlock_cnt_nxt = {UC_W{1'b0}};
                        end else begin
                            unlock_cnt_nxt = unlock_inc_s;
                        end
                    end else begin
                        unlock_cnt_nxt = {UC_W{1'b0}};
                    end
                end
                default: begin
                    state_nxt      = SEARCH;
                    lock_cnt_nxt   = {LC_W{1'b0}};
                    unlock_cnt_nxt = {UC_W{1'b0}};
                end
            endcase
        end else begin
            hist_nxt = hist_r;
        end
        // clear overrides error reporting but never the lock state
        if (clear) begin
            word_err_nxt  = 1'b0;
            err_count_nxt = {CNT_W{1'b0}};
        end else begin
            word_err_nxt  = word_err_upd_s;
            err_count_nxt = err_count_upd_s;
        end
    end

    // State, history, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= SEARCH;
            lock_cnt_r   <= {LC_W{1'b0}};
            unlock_cnt_r <= {UC_W{1'b0}};
            hist_r       <= 7'd0;
            locked_r     <= 1'b0;
            word_err_r   <= 1'b0;
            err_bits_r   <= 6'd0;
            err_count_r  <= {CNT_W{1'b0}};
        end else begin
            state_r      <= state_nxt;
            lock_cnt_r   <= lock_cnt_nxt;
            unlock_cnt_r <= unlock_cnt_nxt;
            hist_r       <= hist_nxt;
            locked_r     <= (state_nxt == LOCKED);
            word_err_r   <= word_err_nxt;
            err_bits_r   <= err_bits_nxt;
            err_count_r  <= err_count_nxt;
        end
    end

    assign locked    = locked_r;
    assign word_err  = word_err_r;
    assign err_bits  = err_bits_r;
    assign err_count = err_count_r;

endmodule

// File: tb/tb_prbs_checker.sv
// Directed table-driven bench for prbs_checker; a second instance with a
// 6-bit counter exercises err_count saturation on the same stream.
module tb_prbs_checker;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        in_valid;
    logic [31:0] in_data;
    logic        locked, word_err;
    logic [5:0]  err_bits;
    logic [31:0] err_count;
    logic        s_locked, s_word_err;
    logic [5:0]  s_err_bits;
    logic [5:0]  s_err_count;

    prbs_checker dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(locked), .word_err(word_err), .err_bits(err_bits), .err_count(err_count)
    );

    prbs_checker #(.CNT_W(6)) dut_sat (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .locked(s_locked), .word_err(s_word_err), .err_bits(s_err_bits), .err_count(s_err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        clr;
        logic [31:0] data;
        logic        e_locked;
        logic        e_werr;
        logic [5:0]  e_bits;
        logic [31:0] e_count;
    } vec_t;

    localparam logic [31:0] FLIP20 = 32'h0010_0000;

    vec_t        vq[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [6:0]  g;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    endtask

    // PRBS7 generator: newest bit in g[0], first generated bit lands in the MSB.
    task automatic gen(output logic [31:0] w);
        logic b;
        w = 32'd0;
        for (int i = 0; i < 32; i++) begin
            b = g[6] ^ g[5];
            w = {w[30:0], b};
            g = {g[5:0], b};
        end
    endtask

    // Bit-serial reference: e[n] = b[n] ^ b[n-7] ^ b[n-6] over history then word.
    function automatic int ref_err(input logic [6:0] h, input logic [31:0] w);
        logic s [0:38];
        int   c;
        c = 0;
        if (h == 7'd0 && w == 32'd0) return 32;
        for (int k = 0; k < 7; k++) s[k] = h[6-k];
        for (int n = 0; n < 32; n++) s[7+n] = w[31-n];
        for (int n = 0; n < 32; n++) c += int'(s[7+n] ^ s[n] ^ s[n+1]);
        return c;
    endfunction

    task automatic add(input logic v, input logic clr, input logic [31:0] d, input logic el,
                       input logic ew, input logic [5:0] eb, input logic [31:0] ec);
        vec_t t;
        t.valid = v; t.clr = clr; t.data = d;
        t.e_locked = el; t.e_werr = ew; t.e_bits = eb; t.e_count = ec;
        vq.push_back(t);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".locked"},    {31'd0, locked},      32'd0);
        check({tag, ".word_err"},  {31'd0, word_err},    32'd0);
        check({tag, ".err_bits"},  {26'd0, err_bits},    32'd0);
        check({tag, ".err_count"}, err_count,            32'd0);
        check({tag, ".sat_count"}, {26'd0, s_err_count}, 32'd0);
    endtask

    task automatic run_table(input string tag);
        logic [31:0] sc;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            in_valid = vq[i].valid;
            clear    = vq[i].clr;
            in_data  = vq[i].data;
            @(posedge clk);
            #1;
            sc = (vq[i].e_count > 32'd63) ? 32'd63 : vq[i].e_count;
            check($sformatf("%s[%0d].locked", tag, i),    {31'd0, locked},      {31'd0, vq[i].e_locked});
            check($sformatf("%s[%0d].word_err", tag, i),  {31'd0, word_err},    {31'd0, vq[i].e_werr});
            check($sformatf("%s[%0d].err_bits", tag, i),  {26'd0, err_bits},    {26'd0, vq[i].e_bits});
            check($sformatf("%s[%0d].err_count", tag, i), err_count,            vq[i].e_count);
            check($sformatf("%s[%0d].sat_count", tag, i), {26'd0, s_err_count}, sc);
            check($sformatf("%s[%0d].sat_locked", tag, i), {31'd0, s_locked},   {31'd0, vq[i].e_locked});
            check($sformatf("%s[%0d].sat_werr", tag, i),  {26'd0, s_err_bits, 1'b0} >> 1, {26'd0, vq[i].e_bits});
            check($sformatf("%s[%0d].sat_word_err", tag, i), {31'd0, s_word_err}, {31'd0, vq[i].e_werr});
            in_valid = 1'b0;
            clear    = 1'b0;
        end
        vq.delete();
    endtask

    // Fresh lock acquisition from seed 7'h7F: the first word only violates at b6.
    task automatic add_lock_seq(input int nwords);
        logic [31:0] w;
        g = 7'h7F;
        for (int j = 1; j <= nwords; j++) begin
            gen(w);
            add(1'b1, 1'b0, w, (j >= 5), 1'b0, (j == 1) ? 6'd1 : 6'd0, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] w, last;
        int          k, r;

        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 32'd0;
        #1 reset = 1'b1;
        #1 check_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Lock, single-bit flip, zero-word unlock, relock, saturation, clear
        add_lock_seq(10);
        gen(w); add(1'b1, 1'b0, w ^ FLIP20, 1'b1, 1'b1, 6'd3, 32'd3);
        gen(w); add(1'b1, 1'b0, w, 1'b1, 1'b0, 6'd0, 32'd3);
        last = w;
        k = ref_err(last[6:0], 32'd0);
        add(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 6'(k), 32'(3 + k));
        add(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 6'd32, 32'(35 + k));
        add(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 6'd32, 32'(67 + k));
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 6'd32, 32'(99 + k));
        gen(w); r = ref_err(7'd0, w);
        add(1'b1, 1'b0, w, 1'b0, 1'b0, 6'(r), 32'(99 + k));
        for (int j = 2; j <= 5; j++) begin
            gen(w); add(1'b1, 1'b0, w, (j == 5), 1'b0, 6'd0, 32'(99 + k));
        end
        gen(w); add(1'b1, 1'b1, w ^ FLIP20, 1'b1, 1'b0, 6'd3, 32'd0);
        gen(w); add(1'b1, 1'b0, w ^ FLIP20, 1'b1, 1'b1, 6'd3, 32'd3);
        gen(w); add(1'b1, 1'b0, w ^ FLIP20, 1'b1, 1'b1, 6'd3, 32'd6);
        gen(w); add(1'b1, 1'b0, w ^ FLIP20, 1'b0, 1'b1, 6'd3, 32'd9);
        add(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 6'd3, 32'd0);
        run_table("main");

        // in_valid toggling: idle cycles carry garbage and must hold everything
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        g = 7'h7F;
        for (int j = 1; j <= 7; j++) begin
            gen(w);
            add(1'b1, 1'b0, w, (j >= 5), 1'b0, (j == 1) ? 6'd1 : 6'd0, 32'd0);
            add(1'b0, 1'b0, 32'hFFFF_0000, (j >= 5), 1'b0, (j == 1) ? 6'd1 : 6'd0, 32'd0);
        end
        gen(w); add(1'b1, 1'b0, w ^ FLIP20, 1'b1, 1'b1, 6'd3, 32'd3);
        run_table("toggle");

        // Async reset while locked with word_err high: outputs drop before any clock edge
        gen(w);
        in_valid = 1'b1;
        in_data  = w;
        #2 reset = 1'b1;
        #1 check_zero("async_reset");
        @(posedge clk);
        #1 check_zero("reset_held");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        add_lock_seq(6);
        run_table("relock");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
